// File: rtl/wb_chunker.sv
// rtl/wb_chunker.sv - serialises prefetched WIDTH-bit words into CHUNK-bit Wishbone reads; optional macro WB_CHUNKER_PIPELINED_EN
module wb_chunker #(
  parameter int WIDTH     = 48,
  parameter int CHUNK     = 8,
  parameter int COUNT     = (WIDTH + CHUNK - 1) / CHUNK,
  parameter int DEPTH     = 2,
  parameter int ABITS     = 1,
  parameter bit MSB_FIRST = 1'b0,
  parameter int DELAY     = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  output logic             ack_o,
  output logic             stall_o,
  input  logic [CHUNK-1:0] dat_i,
  output logic [CHUNK-1:0] dat_o,
  output logic             fetch_o,
  input  logic             ready_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             valid_o,
  output logic [ABITS:0]   level_o
);

  localparam int IBITS = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int PBITS = COUNT * CHUNK;
  localparam logic [IBITS-1:0] LAST_IDX   = IBITS'(COUNT - 1);
  localparam logic [ABITS:0]   FULL_LEVEL = (ABITS + 1)'(DEPTH);

  // FIFO storage and bookkeeping
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [ABITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ABITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ABITS:0]   level_q, level_d;

  // Serialiser: one word plus the index of the next chunk to hand out
  logic [WIDTH-1:0] word_q, word_d;
  logic [IBITS-1:0] idx_q, idx_d;
  logic             valid_q, valid_d;

  // Bus response and upstream request
  logic             ack_q, ack_d;
  logic [CHUNK-1:0] dat_q, dat_d;
  logic             fetch_q, fetch_d;

  // Decoded per-cycle events
  logic             rd_strobe, wr_strobe;
  logic             rd_take, wr_take;
  logic             stall_w;
  logic             flush, push, pop, last_chunk;
  logic [WIDTH-1:0] head;
  logic [PBITS-1:0] padded;
  logic [CHUNK-1:0] cur_chunk;

  // Only bit 0 of write data carries a command; DELAY has no meaning in hardware
  logic unused_w;
  assign unused_w = ^{dat_i[CHUNK-1:1], DELAY};

  assign head = mem_q[rd_ptr_q];

  // Bus request decode; classic mode blocks new requests while an ack is showing
  always_comb begin
    rd_strobe = cyc_i && stb_i && !we_i;
    wr_strobe = cyc_i && stb_i && we_i;
`ifdef WB_CHUNKER_PIPELINED_EN
    stall_w   = rd_strobe && !valid_q;
    rd_take   = rd_strobe && valid_q;
    wr_take   = wr_strobe;
`else
    stall_w   = 1'b0;
    rd_take   = rd_strobe && valid_q && !ack_q;
    wr_take   = wr_strobe && !ack_q;
`endif
    flush      = wr_take && dat_i[0];
    last_chunk = (idx_q == LAST_IDX);
    // Refill the serialiser when it is empty or its last chunk leaves this cycle
    pop        = !flush && (level_q != '0) && (!valid_q || (rd_take && last_chunk));
    // A word arriving alongside a flush is dropped with the rest of the buffer
    push       = fetch_q && ready_i && !flush;
  end

  // Current chunk of the zero-extended word, in the configured order
  always_comb begin
    padded             = '0;
    padded[WIDTH-1:0]  = word_q;
    cur_chunk          = '0;
    for (int k = 0; k < COUNT; k++) begin
      if (idx_q == IBITS'(k)) begin
        if (MSB_FIRST) cur_chunk = padded[(COUNT - 1 - k) * CHUNK +: CHUNK];
        else           cur_chunk = padded[k * CHUNK +: CHUNK];
      end
    end
  end

  // Next-state for FIFO, serialiser, bus response and upstream request
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    word_d   = word_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    dat_d    = dat_q;
    ack_d    = rd_take || wr_take;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      idx_d    = '0;
      valid_d  = 1'b0;
    end else begin
      wr_ptr_d = wr_ptr_q + ABITS'(push);
      rd_ptr_d = rd_ptr_q + ABITS'(pop);
      level_d  = level_q + (ABITS + 1)'(push) - (ABITS + 1)'(pop);

      if (rd_take) begin
        dat_d = cur_chunk;
        if (last_chunk) begin
          idx_d   = '0;
          valid_d = pop;
        end else begin
          idx_d   = idx_q + IBITS'(1);
        end
      end

      if (pop) begin
        word_d  = head;
        idx_d   = '0;
        valid_d = 1'b1;
      end
    end

    // Ask upstream for more whenever the FIFO will have room after this cycle
    fetch_d = (level_d < FULL_LEVEL);
  end

  // State registers with synchronous reset; reset abandons any upstream handshake
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      word_q   <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
      fetch_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      word_q   <= word_d;
      idx_q    <= idx_d;
      valid_q  <= valid_d;
      ack_q    <= ack_d;
      dat_q    <= dat_d;
      fetch_q  <= fetch_d;
    end
  end

  // FIFO entries need no reset: level_q gates every read of them
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= value_i;
  end

  assign ack_o   = ack_q;
  assign stall_o = stall_w;
  assign dat_o   = dat_q;
  assign fetch_o = fetch_q;
  assign valid_o = valid_q;
  assign level_o = level_q;

endmodule

// File: tb/tb_wb_chunker.sv
// tb/tb_wb_chunker.sv - directed self-checking bench for wb_chunker
module tb_wb_chunker;

  logic        clk = 1'b0;
  logic        rst, cyc, stb, we, ready;
  logic [7:0]  wdat;
  logic [47:0] value;
  logic [19:0] value20;

  logic        ack_o, stall_o, fetch_o, valid_o;
  logic [7:0]  dat_o;
  logic [1:0]  level_o;

  logic        m_ack, m_stall, m_fetch, m_valid;
  logic [7:0]  m_dat;
  logic [1:0]  m_level;
  logic        l_ack, l_stall, l_fetch, l_valid;
  logic [7:0]  l_dat;
  logic [1:0]  l_level;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_chunker dut (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .ack_o(ack_o), .stall_o(stall_o), .dat_i(wdat), .dat_o(dat_o),
    .fetch_o(fetch_o), .ready_i(ready), .value_i(value),
    .valid_o(valid_o), .level_o(level_o)
  );

  wb_chunker #(.WIDTH(20), .CHUNK(8), .MSB_FIRST(1'b1)) dut_m (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .ack_o(m_ack), .stall_o(m_stall), .dat_i(wdat), .dat_o(m_dat),
    .fetch_o(m_fetch), .ready_i(ready), .value_i(value20),
    .valid_o(m_valid), .level_o(m_level)
  );

  wb_chunker #(.WIDTH(20), .CHUNK(8), .MSB_FIRST(1'b0)) dut_l (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .we_i(we),
    .ack_o(l_ack), .stall_o(l_stall), .dat_i(wdat), .dat_o(l_dat),
    .fetch_o(l_fetch), .ready_i(ready), .value_i(value20),
    .valid_o(l_valid), .level_o(l_level)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; ready = 1'b0; wdat = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [47:0] w, input logic [19:0] w20);
    int n;
    value = w; value20 = w20; ready = 1'b1; n = 0;
    while (!fetch_o && n < 8) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    ready = 1'b0;
  endtask

  task automatic bus_read(output logic [7:0] d, output logic [7:0] dm,
                          output logic [7:0] dl, output int lat);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!ack_o && lat < 12);
    if (!ack_o) lat = 99;
    d = dat_o; dm = m_dat; dl = l_dat;
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [7:0] v, output int lat);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; wdat = v; lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!ack_o && lat < 12);
    if (!ack_o) lat = 99;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; wdat = '0;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0]  d, dm, dl;
    logic [95:0] pair;
    logic [7:0]  exp_m [3];
    logic [7:0]  exp_l [3];
    int          lat, max_lat;
    logic        any_ack;

    exp_m = '{8'h0A, 8'hBC, 8'hDE};
    exp_l = '{8'hDE, 8'hBC, 8'h0A};
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; ready = 1'b0;
    wdat = '0; value = '0; value20 = '0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_ack",   ack_o,   0);
    check_eq("rst_stall", stall_o, 0);
    check_eq("rst_fetch", fetch_o, 0);
    check_eq("rst_valid", valid_o, 0);
    check_eq("rst_level", level_o, 0);
    check_eq("rst_dat",   dat_o,   0);
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("fetch_after_rst", fetch_o, 1);

    // Single word, six LSB-first chunks
    push_word(48'h060504030201, 20'h0);
    check_eq("t1_level_push", level_o, 1);
    @(posedge clk); #1;
    check_eq("t1_valid_load", valid_o, 1);
    check_eq("t1_level_pop",  level_o, 0);
    check_eq("t1_fetch_pop",  fetch_o, 1);
    max_lat = 0;
    for (int i = 0; i < 6; i++) begin
      bus_read(d, dm, dl, lat);
      check_eq($sformatf("t1_chunk%0d", i), d, 64'(i + 1));
      if (lat > max_lat) max_lat = lat;
    end
    check_eq("t1_max_latency", max_lat, 1);
    check_eq("t1_valid_empty", valid_o, 0);

    // Read with no data: wait states until upstream supplies a word
    cyc = 1'b1; stb = 1'b1; we = 1'b0; any_ack = 1'b0;
    repeat (3) begin
      @(posedge clk); #1; any_ack |= ack_o;
    end
    check_eq("t4_no_ack", any_ack, 0);
`ifdef WB_CHUNKER_PIPELINED_EN
    check_eq("t4_stall", stall_o, 1);
`else
    check_eq("t4_stall", stall_o, 0);
`endif
    value = 48'hA5A5A5A5A511; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0; lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!ack_o && lat < 10);
    check_eq("t4_ack_latency", lat, 2);
    check_eq("t4_dat", dat_o, 8'h11);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;

    // Two queued words behind a loaded one: no wait states across the boundary
    do_reset();
    push_word(48'h0C0B0A090807, 20'h0);
    push_word(48'h060504030201, 20'h0);
    push_word(48'h1211100F0E0D, 20'h0);
    check_eq("t2_level_full", level_o, 2);
    check_eq("t2_valid",      valid_o, 1);
    check_eq("t2_fetch_full", fetch_o, 0);
    pair = {48'h060504030201, 48'h0C0B0A090807};
    max_lat = 0;
    for (int i = 0; i < 12; i++) begin
      bus_read(d, dm, dl, lat);
      check_eq($sformatf("t2_chunk%0d", i), d, 64'(pair[8 * i +: 8]));
      if (lat > max_lat) max_lat = lat;
    end
    check_eq("t2_max_latency", max_lat, 1);
    check_eq("t2_level_end",   level_o, 0);
    check_eq("t2_valid_end",   valid_o, 1);
    check_eq("t2_fetch_end",   fetch_o, 1);

    // 20-bit words, MSB-first and LSB-first with zero padding
    do_reset();
    push_word(48'h0, 20'hABCDE);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      bus_read(d, dm, dl, lat);
      check_eq($sformatf("t3_msb%0d", i), dm, 64'(exp_m[i]));
      check_eq($sformatf("t3_lsb%0d", i), dl, 64'(exp_l[i]));
    end
    check_eq("t3_msb_valid_end", m_valid, 0);

    // Flush after three of six chunks
    do_reset();
    push_word(48'h060504030201, 20'h0);
    push_word(48'h0C0B0A090807, 20'h0);
    for (int i = 0; i < 3; i++) begin
      bus_read(d, dm, dl, lat);
      check_eq($sformatf("t5_chunk%0d", i), d, 64'(i + 1));
    end
    bus_write(8'h00, lat);
    check_eq("t5_nop_ack",   lat,     1);
    check_eq("t5_nop_valid", valid_o, 1);
    check_eq("t5_nop_level", level_o, 1);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; wdat = 8'h01;
    value = 48'hDEADDEADDEAD; ready = 1'b1;
    @(posedge clk); #1;
    ready = 1'b0;
    check_eq("t5_flush_ack",   ack_o,   1);
    check_eq("t5_flush_level", level_o, 0);
    check_eq("t5_flush_valid", valid_o, 0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0; wdat = '0;
    @(posedge clk); #1;
    check_eq("t5_fetch_after", fetch_o, 1);
    push_word(48'h2A2B2C2D2E2F, 20'h0);
    bus_read(d, dm, dl, lat);
    check_eq("t5_fresh_chunk0", d, 8'h2F);

    // Reset during a read with a full FIFO
    do_reset();
    push_word(48'h0C0B0A090807, 20'h0);
    push_word(48'h060504030201, 20'h0);
    push_word(48'h1211100F0E0D, 20'h0);
    check_eq("t6_level_full", level_o, 2);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    check_eq("t6_ack",   ack_o,   0);
    check_eq("t6_level", level_o, 0);
    check_eq("t6_valid", valid_o, 0);
    check_eq("t6_fetch", fetch_o, 0);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check_eq("t6_fetch_after", fetch_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
